nonce_receiver: RTL and testbench
=================================

# nonce_receiver

Reader side of the nonce buffer's serial result link. It drives `readready` to the buffer and samples the buffer's 1-bit serial nonce line. It reassembles each framed 32-bit winning nonce and presents it to the host-side consumer through a valid/ack holding register. It also latches the buffer's overflow indication and counts good and bad frames for status readout.

## Interface
Parameters:
- `NONCE_W`, 32, nonce width in bits; frame data length.
- `CNT_W`, 16, width of the frame counters.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `nonce_i`  in  1  serial line from buffer `nonce_o`.
- `overflow_i`  in  1  buffer `overflow` flag.
- `readready`  out  1  to buffer; receiver can accept or is accepting a frame.
- `nonce_o`  out  NONCE_W  assembled nonce; stable while `nonce_valid`.
- `nonce_valid`  out  1  `nonce_o` holds an unconsumed nonce.
- `nonce_ack`  in  1  consumer accepts `nonce_o` on the cycle `nonce_valid`&&`nonce_ack`.
- `overflow_seen`  out  1  sticky; buffer overflow has been observed since reset.
- `framing_err`  out  1  sticky; a frame with a bad stop bit has been discarded.
- `good_frames`  out  CNT_W  count of nonces delivered.
- `bad_frames`  out  CNT_W  count of discarded frames.

## Operation
- Frame format on `nonce_i` (one bit per clk, only while `readready`=1):
  - start bit 1;
  - NONCE_W data bits, LSB first;
  - stop bit 0.
  - The line idles at 0.
- FSM states: IDLE, SHIFT, STOP, HOLD.
  - **IDLE:** `readready`=1. `nonce_i`=1 → SHIFT, with bit counter cleared. `nonce_i`=0 → stay in IDLE.
  - **SHIFT:** each cycle, shift `nonce_i` into bit position [counter] and increment the counter. After bit NONCE_W-1 is sampled → STOP.
  - **STOP:**
    - `nonce_i`=0 → load the holding register, `good_frames`++, go to HOLD.
    - `nonce_i`=1 → discard the frame, set `framing_err`, `bad_frames`++, go to IDLE.
  - **HOLD:** `readready`=0 and `nonce_valid`=1. `nonce_ack`=1 → IDLE next cycle. `nonce_i` is ignored.
- `overflow_seen` sets on any cycle with `overflow_i`=1. Only `rst` clears it. It is independent of FSM state.
- Counters saturate at all-ones; they do not wrap.
- `nonce_o` changes only on entry to HOLD and otherwise retains its value, including after ack.

## Timing
- Reset values:
  - `readready`=0, `nonce_valid`=0, `nonce_o`=0;
  - `overflow_seen`=0, `framing_err`=0;
  - both counters 0; state IDLE.
- `readready` is registered: it is 1 in the first cycle after `rst` deasserts.
- If the start bit is sampled at edge t:
  - data bits are sampled at t+1..t+NONCE_W;
  - the stop bit is sampled at t+NONCE_W+1;
  - `nonce_valid`=1 from cycle t+NONCE_W+2 (34-cycle latency from start bit for NONCE_W=32).
- `readready` falls in the same cycle `nonce_valid` rises. It returns to 1 the cycle after the ack edge.
- Ack in the first valid cycle is legal: `nonce_valid` is high for exactly 1 cycle.
- `nonce_ack` while `nonce_valid`=0 has no effect.
- Simultaneous `overflow_i` and stop-bit error: both sticky flags set in the same cycle.
- `rst` asserted mid-frame or in HOLD:
  - the frame is abandoned and counters clear;
  - all outputs take reset values at the next edge;
  - no partial nonce is ever presented.
- Counter increments are registered: visible one cycle after the STOP-state edge.

## Structure
- Shared package `nonce_pkg` holds:
  - `NONCE_W` default;
  - `START_BIT`=1 and `STOP_BIT`=0 constants;
  - the `rx_state_t` enum {IDLE, SHIFT, STOP, HOLD};
  - the bit-counter width `$clog2(NONCE_W)`.
- The buffer uses the same package constants for its transmitter side.
- Natural sub-module: `nonce_rx_shifter`, containing the shift register and bit counter with `clear`, `shift_en`, `done` ports. The FSM, holding register, flags and counters live in `nonce_receiver`.

## Test plan
- **Single frame:** send start, data 25 (LSB first), stop 0; hold `nonce_ack`=0 for 5 cycles, then pulse it. Required:
  - `nonce_valid` rises 34 cycles after the start bit, with `nonce_o`=25;
  - `readready`=0 while valid;
  - `good_frames`=1;
  - `readready`=1 the cycle after the ack.
- **Back-to-back frames:** send 0xDEADBEEF then 0x00000001, with the second start bit the cycle after `readready` returns. Required: both are delivered in order with correct values, `good_frames`=2, `bad_frames`=0.
- **Framing error:** send a frame with 0x12345678 and stop bit 1. Required:
  - `nonce_valid` stays 0;
  - `framing_err`=1, `bad_frames`=1;
  - the next valid frame 0xA5A5A5A5 is still delivered.
- **Overflow latch:** pulse `overflow_i` for 1 cycle during SHIFT. Required:
  - `overflow_seen`=1 and stays 1;
  - the in-flight frame is delivered normally;
  - only `rst` clears the flag.
- **Reset mid-frame:** assert `rst` for 1 cycle at data bit 10, then send a full frame with 0x0000FFFF. Required:
  - all outputs are at reset values after the reset edge;
  - the next frame decodes to 0x0000FFFF;
  - `good_frames`=1.
- **Idle noise and stray ack:** hold `nonce_i`=0 for 100 cycles and pulse `nonce_ack` while `nonce_valid`=0. Required: no state change, both counters 0.

Source files
------------

// File: rtl/nonce_pkg.sv
// Shared constants and types for the nonce buffer serial result link.
// The transmitter (buffer) and receiver both frame data with these values.
package nonce_pkg;
    localparam int unsigned NONCE_W_DEF = 32;
    localparam logic        START_BIT   = 1'b1;
    localparam logic        STOP_BIT    = 1'b0;
    localparam int unsigned BITCNT_W    = $clog2(NONCE_W_DEF);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        STOP,
        HOLD
    } rx_state_t;
endpackage

// File: rtl/nonce_rx_shifter.sv
// Deserialiser for the nonce link: writes each incoming bit at the position
// given by the bit counter (LSB first) and flags the last data bit.
module nonce_rx_shifter
    import nonce_pkg::*;
#(
    parameter int unsigned NONCE_W = NONCE_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               shift_en,
    input  logic               bit_i,
    output logic [NONCE_W-1:0] data_o,
    output logic               done
);
    localparam int unsigned CW   = (NONCE_W > 1) ? $clog2(NONCE_W) : 1;
    localparam logic [CW-1:0] LAST = CW'(NONCE_W - 1);

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NONCE_W-1:0] data_q, data_d;

    always_comb begin
        cnt_d  = cnt_q;
        data_d = data_q;
        if (clear) begin
            cnt_d = '0;
        end else if (shift_en) begin
            data_d[cnt_q] = bit_i;
            cnt_d         = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign data_o = data_q;
    assign done   = shift_en && (cnt_q == LAST);
endmodule

// File: rtl/nonce_receiver.sv
// Reader side of the nonce buffer serial link: frames, holds and acks each
// nonce, latches buffer overflow and keeps saturating good/bad frame counts.
module nonce_receiver
    import nonce_pkg::*;
#(
    parameter int unsigned NONCE_W = NONCE_W_DEF,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               nonce_i,
    input  logic               overflow_i,
    output logic               readready,
    output logic [NONCE_W-1:0] nonce_o,
    output logic               nonce_valid,
    input  logic               nonce_ack,
    output logic               overflow_seen,
    output logic               framing_err,
    output logic [CNT_W-1:0]   good_frames,
    output logic [CNT_W-1:0]   bad_frames
);
    rx_state_t          state_q, state_d;
    logic               ready_q, ready_d;
    logic [NONCE_W-1:0] hold_q, hold_d;
    logic               ovf_q, ovf_d;
    logic               ferr_q, ferr_d;
    logic [CNT_W-1:0]   good_q, good_d;
    logic [CNT_W-1:0]   bad_q, bad_d;

    logic               sh_clear, sh_en, sh_done;
    logic [NONCE_W-1:0] sh_data;

    nonce_rx_shifter #(.NONCE_W(NONCE_W)) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .clear    (sh_clear),
        .shift_en (sh_en),
        .bit_i    (nonce_i),
        .data_o   (sh_data),
        .done     (sh_done)
    );

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        ferr_d   = ferr_q;
        good_d   = good_q;
        bad_d    = bad_q;
        ovf_d    = ovf_q | overflow_i;
        sh_clear = 1'b0;
        sh_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                sh_clear = 1'b1;
                // The line is only meaningful once readready has been presented.
                if (ready_q && (nonce_i == START_BIT)) state_d = SHIFT;
            end
            SHIFT: begin
                sh_en = 1'b1;
                if (sh_done) state_d = STOP;
            end
            STOP: begin
                if (nonce_i == STOP_BIT) begin
                    hold_d  = sh_data;
                    good_d  = (good_q == '1) ? good_q : good_q + CNT_W'(1);
                    state_d = HOLD;
                end else begin
                    ferr_d  = 1'b1;
                    bad_d   = (bad_q == '1) ? bad_q : bad_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (nonce_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d != HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            hold_q  <= '0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
            good_q  <= '0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            hold_q  <= hold_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
        end
    end

    assign readready     = ready_q;
    assign nonce_valid   = (state_q == HOLD);
    assign nonce_o       = hold_q;
    assign overflow_seen = ovf_q;
    assign framing_err   = ferr_q;
    assign good_frames   = good_q;
    assign bad_frames    = bad_q;
endmodule

// File: tb/tb_nonce_receiver.sv
// Directed bench for nonce_receiver with a scoreboard of expected nonces.
module tb_nonce_receiver;
    localparam int unsigned NW = 32;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst, nonce_i, overflow_i, nonce_ack;
    logic          readready, nonce_valid, overflow_seen, framing_err;
    logic [NW-1:0] nonce_o;
    logic [CW-1:0] good_frames, bad_frames;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [NW-1:0] sb_q[$];
    logic [NW-1:0] last_nonce;
    int unsigned   exp_good = 0;
    int unsigned   exp_bad  = 0;
    bit            aborted;

    nonce_receiver #(.NONCE_W(NW), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .nonce_i       (nonce_i),
        .overflow_i    (overflow_i),
        .readready     (readready),
        .nonce_o       (nonce_o),
        .nonce_valid   (nonce_valid),
        .nonce_ack     (nonce_ack),
        .overflow_seen (overflow_seen),
        .framing_err   (framing_err),
        .good_frames   (good_frames),
        .bad_frames    (bad_frames)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_readready"}, readready, 0);
        chk({tag, "_valid"}, nonce_valid, 0);
        chk({tag, "_nonce"}, nonce_o, 0);
        chk({tag, "_ovf"}, overflow_seen, 0);
        chk({tag, "_ferr"}, framing_err, 0);
        chk({tag, "_good"}, good_frames, 0);
        chk({tag, "_bad"}, bad_frames, 0);
    endtask

    // Start bit, NW data bits LSB first, stop bit; optional overflow pulse or
    // reset at a chosen data bit index (-1 = none).
    task automatic send_frame(input logic [NW-1:0] d, input logic stop_b,
                              input int ovf_at, input int rst_at, output bit abrt);
        abrt    = 1'b0;
        nonce_i = 1'b1;
        tick();
        for (int i = 0; i < int'(NW); i++) begin
            nonce_i    = d[i];
            overflow_i = (i == ovf_at);
            if (i == rst_at) rst = 1'b1;
            tick();
            overflow_i = 1'b0;
            if (rst) begin
                rst     = 1'b0;
                nonce_i = 1'b0;
                abrt    = 1'b1;
                return;
            end
        end
        chk("valid_before_stop", nonce_valid, 0);
        nonce_i = stop_b;
        tick();
        nonce_i = 1'b0;
        if (stop_b == 1'b0) begin
            sb_q.push_back(d);
            exp_good++;
        end else begin
            exp_bad++;
        end
    endtask

    task automatic deliver(input int ack_delay);
        logic [NW-1:0] exp;
        chk("valid_at_latency", nonce_valid, 1);
        chk("readready_low_in_hold", readready, 0);
        chk("good_count", good_frames, exp_good);
        if (sb_q.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
            exp = '0;
        end else begin
            exp = sb_q.pop_front();
        end
        chk("nonce_value", nonce_o, exp);
        for (int i = 0; i < ack_delay; i++) begin
            tick();
            chk("valid_held", nonce_valid, 1);
            chk("nonce_stable", nonce_o, exp);
        end
        nonce_ack = 1'b1;
        tick();
        nonce_ack = 1'b0;
        chk("valid_cleared_by_ack", nonce_valid, 0);
        chk("readready_after_ack", readready, 1);
        chk("nonce_retained", nonce_o, exp);
        last_nonce = exp;
    endtask

    initial begin
        rst = 1'b1; nonce_i = 1'b0; overflow_i = 1'b0; nonce_ack = 1'b0;
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();
        chk("readready_after_reset", readready, 1);

        // Idle line with a stray ack: nothing moves.
        for (int i = 0; i < 100; i++) begin
            nonce_ack = (i == 40);
            tick();
        end
        nonce_ack = 1'b0;
        chk("idle_valid", nonce_valid, 0);
        chk("idle_readready", readready, 1);
        chk("idle_good", good_frames, 0);
        chk("idle_bad", bad_frames, 0);
        chk("idle_nonce", nonce_o, 0);

        // Single frame, ack after 5 held cycles.
        send_frame(32'd25, 1'b0, -1, -1, aborted);
        deliver(5);
        chk("single_good", good_frames, 1);

        // Back-to-back, ack in the first valid cycle.
        send_frame(32'hDEADBEEF, 1'b0, -1, -1, aborted);
        deliver(0);
        send_frame(32'h00000001, 1'b0, -1, -1, aborted);
        deliver(0);
        chk("b2b_good", good_frames, exp_good);
        chk("b2b_bad", bad_frames, 0);

        // Bad stop bit then a good frame.
        send_frame(32'h12345678, 1'b1, -1, -1, aborted);
        chk("ferr_valid", nonce_valid, 0);
        chk("ferr_flag", framing_err, 1);
        chk("ferr_bad", bad_frames, exp_bad);
        chk("ferr_nonce_unchanged", nonce_o, last_nonce);
        chk("ferr_readready", readready, 1);
        send_frame(32'hA5A5A5A5, 1'b0, -1, -1, aborted);
        deliver(2);

        // Overflow pulse mid-frame.
        chk("ovf_before", overflow_seen, 0);
        send_frame(32'hCAFEF00D, 1'b0, 5, -1, aborted);
        chk("ovf_seen", overflow_seen, 1);
        deliver(1);
        for (int i = 0; i < 10; i++) tick();
        chk("ovf_sticky", overflow_seen, 1);
        chk("ferr_sticky", framing_err, 1);

        // Reset at data bit 10 abandons the frame.
        send_frame(32'hFFFFFFFF, 1'b0, -1, 10, aborted);
        chk("rst_aborted", aborted, 1);
        chk_reset_vals("midreset");
        sb_q.delete();
        exp_good = 0;
        exp_bad  = 0;
        tick();
        chk("readready_after_midreset", readready, 1);
        send_frame(32'h0000FFFF, 1'b0, -1, -1, aborted);
        deliver(0);
        chk("post_reset_good", good_frames, 1);
        chk("post_reset_bad", bad_frames, 0);
        chk("post_reset_ovf", overflow_seen, 0);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
